video_test_pattern_generator: RTL and testbench

Selectable-mode RGB test pattern source for the HDMI/DVI pixel path. It sits between the video format timing generator and the text overlay or HDMI encoder. It consumes timing (data enable, syncs, hPos/vPos, preamble/guard band) and emits RGB plus the same timing signals delayed to stay aligned. It generalises the fixed-pattern test top with runtime mode selection, parametrised colour depth and resolution, frame-synchronous mode switching and animated patterns.

---
 rtl/video_test_pattern_generator.sv | 134 +++++++++++++
 tb/tb_video_test_pattern_generator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/video_test_pattern_generator.sv
// video_test_pattern_generator: selectable RGB test pattern source with timing kept aligned to RGB.
// Ports: timing in (dataEnableIn, syncs, preamble/guard, hPosIn/vPosIn), control (modeSelect, hActive,
// solidColor, animationStep), timing out delayed 3 enabled cycles, red/green/blue, activeMode, frameCount.
module video_test_pattern_generator #(
  parameter int H_BITS = 12,
  parameter int V_BITS = 11,
  parameter int COLOR_BITS = 8,
  parameter int FRAME_COUNT_BITS = 8,
  parameter int CHECKER_SHIFT = 4
) (
  input  logic                        pixelClock,
  input  logic                        reset,
  input  logic                        pixelEnable,
  input  logic                        dataEnableIn,
  input  logic                        hSyncIn,
  input  logic                        vSyncIn,
  input  logic                        activeVideoPreambleIn,
  input  logic                        activeVideoGuardBandIn,
  input  logic [H_BITS-1:0]           hPosIn,
  input  logic [V_BITS-1:0]           vPosIn,
  input  logic [2:0]                  modeSelect,
  input  logic [H_BITS-1:0]           hActive,
  input  logic [3*COLOR_BITS-1:0]     solidColor,
  input  logic [3:0]                  animationStep,
  output logic                        dataEnableOut,
  output logic                        hSyncOut,
  output logic                        vSyncOut,
  output logic                        activeVideoPreambleOut,
  output logic                        activeVideoGuardBandOut,
  output logic [COLOR_BITS-1:0]       red,
  output logic [COLOR_BITS-1:0]       green,
  output logic [COLOR_BITS-1:0]       blue,
  output logic [2:0]                  activeMode,
  output logic [FRAME_COUNT_BITS-1:0] frameCount
);
  localparam int CB = COLOR_BITS;
  localparam int AW = (H_BITS > CB ? H_BITS : CB) + 1;
  localparam int MW = H_BITS > V_BITS ? H_BITS : V_BITS;
  localparam int FW = FRAME_COUNT_BITS < CB ? FRAME_COUNT_BITS : CB;
  localparam logic [AW-1:0] STEP = AW'(2 ** CB);
  logic [4:0] t1_q, t2_q, t3_q;
  logic [CB-1:0] hcol1_q, vcol1_q, ramp1_q;
  logic chk1_q;
  logic [2:0] idx1_q;
  logic [3*CB-1:0] rgb2_q, rgb3_q, rgb_d;
  logic [H_BITS-1:0] cnt_q, cnt_c, cnt_d, bw_m1;
  logic [2:0] idx_q, idx_c, idx_d;
  logic [AW-1:0] acc_q, acc_c, acc_d, sum;
  logic [CB-1:0] ramp_q, ramp_c, ramp_d, scroll, fcol;
  logic [2:0] mode_q;
  logic [FRAME_COUNT_BITS-1:0] fc_q;
  logic [H_BITS-1:0] hact_q;
  logic [3*CB-1:0] solid_q;
  logic [3:0] step_q;
  logic line_start, bar_end, wrap, frame_evt, chk_c;
  assign line_start = hPosIn == '0;
  assign cnt_c = line_start ? '0 : cnt_q;
  assign idx_c = line_start ? '0 : idx_q;
  assign acc_c = line_start ? '0 : acc_q;
  assign ramp_c = line_start ? '0 : ramp_q;
  assign bw_m1 = (hact_q >> 3) - H_BITS'(1);
  assign bar_end = cnt_c == bw_m1;
  assign cnt_d = bar_end ? '0 : cnt_c + H_BITS'(1);
  assign idx_d = (bar_end && idx_c != 3'd7) ? idx_c + 3'd1 : idx_c;
  // DDA: one colour step per hActive/2^CB pixels, so the ramp spans the active width
  assign sum = acc_c + STEP;
  assign wrap = sum >= AW'(hact_q);
  assign acc_d = wrap ? sum - AW'(hact_q) : sum;
  assign ramp_d = (wrap && !(&ramp_c)) ? ramp_c + CB'(1) : ramp_c;
  assign chk_c = |((MW'(hPosIn >> CHECKER_SHIFT) ^ MW'(vPosIn >> CHECKER_SHIFT)) & MW'(1));
  // t1_q[2] is the previous enabled-cycle vSync, giving the rising-edge frame event
  assign frame_evt = vSyncIn & ~t1_q[2];
  assign scroll = ramp1_q + CB'(fc_q) * CB'(step_q);
  assign fcol = CB'(fc_q >> (FRAME_COUNT_BITS - FW));
  // bar order white..black: R off for idx bit1, G off for idx bit2, B off for idx bit0
  assign rgb_d = mode_q == 3'd0 ? solid_q :
                 mode_q == 3'd1 ? {{CB{~idx1_q[1]}}, {CB{~idx1_q[2]}}, {CB{~idx1_q[0]}}} :
                 mode_q == 3'd2 ? {3{ramp1_q}} :
                 mode_q == 3'd3 ? (chk1_q ? solid_q : '0) :
                 mode_q == 3'd4 ? {hcol1_q, vcol1_q, fcol} :
                 mode_q == 3'd5 ? {3{scroll}} :
                 mode_q == 3'd6 ? {3{vcol1_q}} : '0;
  always_ff @(posedge pixelClock) begin
    if (reset) begin
      t1_q <= '0;
      t2_q <= '0;
      t3_q <= '0;
      hcol1_q <= '0;
      vcol1_q <= '0;
      ramp1_q <= '0;
      chk1_q <= 1'b0;
      idx1_q <= '0;
      rgb2_q <= '0;
      rgb3_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      ramp_q <= '0;
      mode_q <= '0;
      fc_q <= '0;
      hact_q <= '0;
      solid_q <= '0;
      step_q <= '0;
    end else if (pixelEnable) begin
      t1_q <= {dataEnableIn, hSyncIn, vSyncIn, activeVideoPreambleIn, activeVideoGuardBandIn};
      hcol1_q <= CB'(hPosIn);
      vcol1_q <= CB'(vPosIn);
      chk1_q <= chk_c;
      idx1_q <= idx_c;
      ramp1_q <= ramp_c;
      if (dataEnableIn) begin
        cnt_q <= cnt_d;
        idx_q <= idx_d;
        acc_q <= acc_d;
        ramp_q <= ramp_d;
      end
      if (frame_evt) begin
        mode_q <= modeSelect;
        hact_q <= hActive;
        solid_q <= solidColor;
        step_q <= animationStep;
        fc_q <= fc_q + FRAME_COUNT_BITS'(1);
      end
      t2_q <= t1_q;
      rgb2_q <= rgb_d;
      t3_q <= t2_q;
      rgb3_q <= t2_q[4] ? rgb2_q : '0;
    end
  end
  assign {dataEnableOut, hSyncOut, vSyncOut, activeVideoPreambleOut, activeVideoGuardBandOut} = t3_q;
  assign {red, green, blue} = rgb3_q;
  assign activeMode = mode_q;
  assign frameCount = fc_q;
endmodule

// File: tb/tb_video_test_pattern_generator.sv
// tb_video_test_pattern_generator: scoreboard bench for the test pattern generator
module tb_video_test_pattern_generator;
  localparam int HB = 12;
  localparam int VB = 11;
  logic pixelClock = 0, reset = 0, pixelEnable = 0;
  logic de = 0, hs = 0, vs = 0, pre = 0, gb = 0;
  logic [HB-1:0] hpos = 0, hact = 0;
  logic [VB-1:0] vpos = 0;
  logic [2:0] msel = 0;
  logic [23:0] solid = 0;
  logic [3:0] astep = 0;
  logic de_o, hs_o, vs_o, pre_o, gb_o;
  logic [7:0] r, g, b, fcount;
  logic [2:0] amode;
  int errors = 0, checks = 0;
  logic [28:0] sb[$];
  logic [28:0] last_out;
  logic [2:0] m_mode;
  logic [7:0] m_fc;
  logic [11:0] m_hact;
  logic [23:0] m_solid;
  logic [3:0] m_step;
  logic m_vs;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  video_test_pattern_generator dut (
    .pixelClock(pixelClock), .reset(reset), .pixelEnable(pixelEnable),
    .dataEnableIn(de), .hSyncIn(hs), .vSyncIn(vs),
    .activeVideoPreambleIn(pre), .activeVideoGuardBandIn(gb),
    .hPosIn(hpos), .vPosIn(vpos), .modeSelect(msel), .hActive(hact),
    .solidColor(solid), .animationStep(astep),
    .dataEnableOut(de_o), .hSyncOut(hs_o), .vSyncOut(vs_o),
    .activeVideoPreambleOut(pre_o), .activeVideoGuardBandOut(gb_o),
    .red(r), .green(g), .blue(b), .activeMode(amode), .frameCount(fcount)
  );
  always #5 pixelClock = ~pixelClock;
  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s h=%0d v=%0d got=%h exp=%h", tag, hpos, vpos, got, exp);
    end
  endtask
  function automatic logic [28:0] cur_out();
    return {de_o, hs_o, vs_o, pre_o, gb_o, r, g, b};
  endfunction
  function automatic logic [23:0] pattern(input int h, input int v);
    int idx;
    logic [7:0] x;
    case (m_mode)
      3'd0: return m_solid;
      3'd1: begin
        idx = h / (m_hact >> 3);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      3'd2: begin
        x = 8'(h * 256 / m_hact);
        return {3{x}};
      end
      3'd3: return (((h >> 4) ^ (v >> 4)) & 1) != 0 ? m_solid : 24'h0;
      3'd4: return {8'(h), 8'(v), m_fc};
      3'd5: begin
        x = 8'(h * 256 / m_hact + m_fc * m_step);
        return {3{x}};
      end
      3'd6: return {3{8'(v)}};
      default: return 24'h0;
    endcase
  endfunction
  task automatic step(input bit en);
    pixelEnable = en;
    if (en) begin
      if (vs && !m_vs) begin
        m_mode = msel;
        m_hact = hact;
        m_solid = solid;
        m_step = astep;
        m_fc++;
      end
      m_vs = vs;
      sb.push_back({de, hs, vs, pre, gb, de ? pattern(hpos, vpos) : 24'h0});
    end
    @(posedge pixelClock);
    #1;
    if (en) begin
      check("pix", cur_out(), sb.pop_front());
      check("mode", amode, m_mode);
      check("fc", fcount, m_fc);
    end else
      check("hold", cur_out(), last_out);
    last_out = cur_out();
  endtask
  task automatic do_reset();
    reset = 1;
    pixelEnable = 1;
    @(posedge pixelClock);
    #1;
    check("rst_out", cur_out(), 0);
    check("rst_mode", amode, 0);
    check("rst_fc", fcount, 0);
    reset = 0;
    sb.delete();
    sb.push_back(0);
    sb.push_back(0);
    {m_mode, m_fc, m_hact, m_solid, m_step, m_vs} = '0;
    last_out = 0;
  endtask
  task automatic line(input int w, input int v, input int stall);
    for (int h = 0; h < w; h++) begin
      if (h == stall)
        for (int k = 0; k < 5; k++) begin
          hpos = HB'($urandom);
          de = 1'($urandom);
          step(0);
        end
      de = 1;
      hpos = HB'(h);
      vpos = VB'(v);
      step(1);
    end
    de = 0;
    hpos = 0;
    for (int k = 0; k < 6; k++) begin
      hs = k >= 1 && k < 3;
      pre = k == 4;
      gb = k == 5;
      step(1);
    end
    {hs, pre, gb} = '0;
  endtask
  task automatic vblank();
    for (int k = 0; k < 4; k++) begin
      vs = k >= 1 && k < 3;
      step(1);
    end
    vs = 0;
  endtask
  task automatic frame(input int nlines);
    vblank();
    for (int l = 0; l < nlines; l++) line(int'(hact), l, -1);
  endtask
  initial begin
    do_reset();
    msel = 1;
    hact = 1280;
    frame(2);
    msel = 2;
    hact = 256;
    frame(2);
    msel = 1;
    vblank();
    line(256, 0, -1);
    msel = 3;
    solid = 24'hFF0000;
    line(256, 1, -1);
    vblank();
    line(256, 0, -1);
    line(256, 17, 40);
    msel = 2;
    vblank();
    line(256, 3, 100);
    hact = 16;
    for (int f = 0; f < 256; f++) begin
      msel = (f % 8 == 2 || f % 8 == 5) ? 3'd4 : 3'(f % 8);
      solid = 24'($urandom);
      vblank();
      line(16, f * 5, -1);
    end
    do_reset();
    msel = 5;
    astep = 1;
    hact = 256;
    frame(1);
    frame(1);
    astep = 3;
    frame(1);
    msel = 6;
    hact = 16;
    vblank();
    for (int l = 0; l < 300; l++) line(16, l, -1);
    de = 1;
    vpos = 300;
    for (int h = 0; h < 5; h++) begin
      hpos = HB'(h);
      step(1);
    end
    do_reset();
    line(16, 301, -1);
    frame(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
